// File: rtl/elevator_sched_pkg.sv
// Shared types, constants and direction helpers for the elevator car scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int FLOOR_W          = 3;
  localparam int DEF_N_FLOORS     = 5;
  localparam int DEF_TRAVEL_TICKS = 20;
  localparam int DEF_DOOR_TICKS   = 30;

  // Returns {ahead, behind}: requests strictly beyond the car in its travel direction, and strictly on the other side.
  function automatic logic [1:0] aheadBehind(input logic [7:0] req,
                                             input logic [FLOOR_W-1:0] floorNum,
                                             input logic dirUp);
    logic [7:0] below;
    logic [7:0] above;
    below = (8'd1 << floorNum) - 8'd1;
    above = ~(below | (8'd1 << floorNum));
    if (dirUp) return {|(req & above), |(req & below)};
    else       return {|(req & below), |(req & above)};
  endfunction

endpackage

// File: rtl/elevator_sched_if.sv
// Call/status bundle between the elevator scheduler and its surroundings.
// With DOOR_HOLD_EN defined the bundle also carries the door_hold request.
interface elevator_sched_if import elevator_pkg::*; #(
  parameter int N_FLOORS = DEF_N_FLOORS
);

  logic                tick;
  logic [N_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]  floor;
  logic                dir_up;
  logic                moving;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
`ifdef DOOR_HOLD_EN
  logic                door_hold;

  modport master (output tick, call_req, door_hold,
                  input  floor, dir_up, moving, door_open, pending);
  modport slave  (input  tick, call_req, door_hold,
                  output floor, dir_up, moving, door_open, pending);
`else
  modport master (output tick, call_req,
                  input  floor, dir_up, moving, door_open, pending);
  modport slave  (input  tick, call_req,
                  output floor, dir_up, moving, door_open, pending);
`endif

endinterface

// File: rtl/elevator_sched_tick_timer.sv
// Tick-paced down-counter shared by travel and door timing; expire is a tick seen while the count is 1.
module tick_timer import elevator_pkg::*; #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_tick,
  output logic         o_expire,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // A load always wins so the owner can restart the interval on the same cycle it expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_tick && (r_count == W'(1));
  assign o_count  = r_count;

endmodule

// File: rtl/elevator_sched.sv
// Collective (SCAN) car scheduler: latches calls, times travel and door dwell from tick strobes.
// Optional DOOR_HOLD_EN adds a door_hold input that keeps the door open while asserted.
module elevator_sched import elevator_pkg::*; #(
  parameter int N_FLOORS     = DEF_N_FLOORS,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS
) (
  input logic             clk,
  input logic             rst,
  elevator_sched_if.slave bus
);

  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0]       TRAVEL_LOAD = TW'(TRAVEL_TICKS);
  localparam logic [TW-1:0]       DOOR_LOAD   = TW'(DOOR_TICKS);
  localparam logic [N_FLOORS-1:0] HOT_ZERO    = N_FLOORS'(1);

  state_t              r_state;
  logic [FLOOR_W-1:0]  r_floor;
  logic                r_dirUp;
  logic                r_moving;
  logic                r_doorOpen;
  logic [N_FLOORS-1:0] r_pending;

  logic [FLOOR_W-1:0]  w_nextFloor;
  logic [N_FLOORS-1:0] w_floorHot;
  logic [N_FLOORS-1:0] w_nextHot;
  logic [N_FLOORS-1:0] w_clr;
  logic                w_here;
  logic                w_ahead;
  logic                w_behind;
  logic                w_stop;
  logic                w_callHere;
  logic                w_reload;
  logic                w_load;
  logic                w_expire;
  logic [TW-1:0]       w_loadVal;
  logic [TW-1:0]       w_timerCount;

  assign w_floorHot  = HOT_ZERO << r_floor;
  assign w_nextFloor = r_dirUp ? (r_floor + 1'b1) : (r_floor - 1'b1);
  assign w_nextHot   = HOT_ZERO << w_nextFloor;
  assign {w_ahead, w_behind} = aheadBehind(8'(r_pending), r_floor, r_dirUp);
  assign w_here      = |(r_pending & w_floorHot);
  assign w_stop      = |((r_pending | bus.call_req) & w_nextHot);
  assign w_callHere  = |(bus.call_req & w_floorHot);
`ifdef DOOR_HOLD_EN
  assign w_reload    = w_callHere | bus.door_hold;
`else
  assign w_reload    = w_callHere;
`endif

  // Timer reloads and the request-clear mask follow the same decisions the FSM below takes.
  always_comb begin
    w_load    = 1'b0;
    w_loadVal = TRAVEL_LOAD;
    w_clr     = '0;
    case (r_state)
      IDLE: begin
        if (w_here) begin
          w_load    = 1'b1;
          w_loadVal = DOOR_LOAD;
          w_clr     = w_floorHot;
        end else if (w_ahead || w_behind) begin
          w_load    = 1'b1;
        end
      end
      MOVE: begin
        if (w_expire) begin
          w_load = 1'b1;
          if (w_stop) begin
            w_loadVal = DOOR_LOAD;
            w_clr     = w_nextHot;
          end
        end
      end
      DOOR: begin
        w_clr = w_floorHot;
        if (w_reload) begin
          w_load    = 1'b1;
          w_loadVal = DOOR_LOAD;
        end else if (w_expire && (w_ahead || w_behind)) begin
          w_load    = 1'b1;
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  tick_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_loadVal (w_loadVal),
    .i_tick    (bus.tick),
    .o_expire  (w_expire),
    .o_count   (w_timerCount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_floor    <= '0;
      r_dirUp    <= 1'b1;
      r_moving   <= 1'b0;
      r_doorOpen <= 1'b0;
      r_pending  <= '0;
    end else begin
      r_pending <= (r_pending | bus.call_req) & ~w_clr;
      case (r_state)
        IDLE: begin
          if (w_here) begin
            r_state    <= DOOR;
            r_doorOpen <= 1'b1;
          end else if (w_ahead) begin
            r_state    <= MOVE;
            r_moving   <= 1'b1;
          end else if (w_behind) begin
            r_state    <= MOVE;
            r_moving   <= 1'b1;
            r_dirUp    <= ~r_dirUp;
          end
        end
        MOVE: begin
          if (w_expire) begin
            r_floor <= w_nextFloor;
            if (w_stop) begin
              r_state    <= DOOR;
              r_moving   <= 1'b0;
              r_doorOpen <= 1'b1;
            end
          end
        end
        DOOR: begin
          // A same-floor call (or hold) on the expiring tick keeps the door open rather than leaving.
          if (w_expire && !w_reload) begin
            r_doorOpen <= 1'b0;
            if (w_ahead) begin
              r_state  <= MOVE;
              r_moving <= 1'b1;
            end else if (w_behind) begin
              r_state  <= MOVE;
              r_moving <= 1'b1;
              r_dirUp  <= ~r_dirUp;
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_moving   <= 1'b0;
          r_doorOpen <= 1'b0;
        end
      endcase
    end
  end

  assign bus.floor     = r_floor;
  assign bus.dir_up    = r_dirUp;
  assign bus.moving    = r_moving;
  assign bus.door_open = r_doorOpen;
  assign bus.pending   = r_pending;

  // Travel only ever heads toward an outstanding request, so the car can never run past an end floor.
  aMoveHasTarget: assert property (@(posedge clk) disable iff (rst) (r_state == MOVE) |-> w_ahead);
  aFloorInRange:  assert property (@(posedge clk) disable iff (rst) 32'(r_floor) < N_FLOORS);
  aExclusive:     assert property (@(posedge clk) disable iff (rst) !(r_moving && r_doorOpen));
  aTimerArmed:    assert property (@(posedge clk) disable iff (rst) (r_state != IDLE) |-> (w_timerCount != '0));

endmodule

// File: tb/tb_elevator_sched.sv
// Scoreboard bench for elevator_sched with TRAVEL_TICKS=4, DOOR_TICKS=3; covers DOOR_HOLD_EN when defined.
module tb_elevator_sched;
  import elevator_pkg::*;

  localparam int NF = 5;

  typedef struct {
    logic [NF-1:0] callReq;
    int            waitClks;
    logic [2:0]    expFloor;
    logic          expDir;
    logic          expMoving;
    logic          expDoor;
    logic [NF-1:0] expPending;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  vec_t tbl[$];
  vec_t expQ[$];

  always #5 clk = ~clk;

  elevator_sched_if #(.N_FLOORS(NF)) bus ();

  elevator_sched #(.N_FLOORS(NF), .TRAVEL_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(logic [NF-1:0] c, int w, logic [2:0] f, logic d,
                              logic m, logic o, logic [NF-1:0] p);
    vec_t v;
    v.callReq = c; v.waitClks = w; v.expFloor = f; v.expDir = d;
    v.expMoving = m; v.expDoor = o; v.expPending = p;
    return v;
  endfunction

  task automatic stepClk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name);
    vec_t e;
    checks++;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, nothing to compare", name);
    end else begin
      e = expQ.pop_front();
      if (bus.floor === e.expFloor && bus.dir_up === e.expDir && bus.moving === e.expMoving &&
          bus.door_open === e.expDoor && bus.pending === e.expPending) begin
        passes++;
      end else begin
        $display("[TB] FAIL %s: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, want floor=%0d dir_up=%b moving=%b door_open=%b pending=%b",
                 name, bus.floor, bus.dir_up, bus.moving, bus.door_open, bus.pending,
                 e.expFloor, e.expDir, e.expMoving, e.expDoor, e.expPending);
      end
    end
  endtask

  // Calls are held for the first clock of a record only; the check lands waitClks edges later.
  task automatic applyStimulus(input vec_t v, input string name);
    expQ.push_back(v);
    bus.call_req = v.callReq;
    if (v.waitClks > 0) begin
      stepClk(1);
      bus.call_req = '0;
      stepClk(v.waitClks - 1);
    end
    checkOutput(name);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.tick     = 1'b1;
    bus.call_req = '0;
`ifdef DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif

    tbl.push_back(mk(5'b00000, 0, 0, 1, 0, 0, 5'b00000));
    tbl.push_back(mk(5'b01000, 1, 0, 1, 0, 0, 5'b01000));
    tbl.push_back(mk(5'b00000, 1, 0, 1, 1, 0, 5'b01000));
    tbl.push_back(mk(5'b00000, 4, 1, 1, 1, 0, 5'b01000));
    tbl.push_back(mk(5'b00000, 4, 2, 1, 1, 0, 5'b01000));
    tbl.push_back(mk(5'b00000, 3, 2, 1, 1, 0, 5'b01000));
    tbl.push_back(mk(5'b00000, 1, 3, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 2, 3, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 1, 3, 1, 0, 0, 5'b00000));
    tbl.push_back(mk(5'b01000, 1, 3, 1, 0, 0, 5'b01000));
    tbl.push_back(mk(5'b00000, 1, 3, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 2, 3, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 1, 3, 1, 0, 0, 5'b00000));
    tbl.push_back(mk(5'b00001, 1, 3, 1, 0, 0, 5'b00001));
    tbl.push_back(mk(5'b00000, 1, 3, 0, 1, 0, 5'b00001));
    tbl.push_back(mk(5'b00000, 4, 2, 0, 1, 0, 5'b00001));
    tbl.push_back(mk(5'b00000, 8, 0, 0, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 3, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(5'b00001, 1, 0, 0, 0, 0, 5'b00001));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 3, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(5'b00100, 1, 0, 0, 0, 0, 5'b00100));
    tbl.push_back(mk(5'b00000, 1, 0, 1, 1, 0, 5'b00100));
    tbl.push_back(mk(5'b00000, 8, 2, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 3, 2, 1, 0, 0, 5'b00000));
    tbl.push_back(mk(5'b10001, 1, 2, 1, 0, 0, 5'b10001));
    tbl.push_back(mk(5'b00000, 1, 2, 1, 1, 0, 5'b10001));
    tbl.push_back(mk(5'b00000, 8, 4, 1, 0, 1, 5'b00001));
    tbl.push_back(mk(5'b00000, 3, 4, 0, 1, 0, 5'b00001));
    tbl.push_back(mk(5'b00000, 16, 0, 0, 0, 1, 5'b00000));
    tbl.push_back(mk(5'b00000, 3, 0, 0, 0, 0, 5'b00000));

    stepClk(2);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Calls for floors 3 and 1 arrive while climbing from floor 2 toward 4.
    applyStimulus(mk(5'b10000, 1, 0, 0, 0, 0, 5'b10000), "mid_call4");
    applyStimulus(mk(5'b00000, 1, 0, 1, 1, 0, 5'b10000), "mid_depart");
    applyStimulus(mk(5'b00000, 8, 2, 1, 1, 0, 5'b10000), "mid_at2");
    applyStimulus(mk(5'b01010, 1, 2, 1, 1, 0, 5'b11010), "mid_calls");
    applyStimulus(mk(5'b00000, 3, 3, 1, 0, 1, 5'b10010), "mid_door3");
    applyStimulus(mk(5'b00000, 3, 3, 1, 1, 0, 5'b10010), "mid_leave3");
    applyStimulus(mk(5'b00000, 4, 4, 1, 0, 1, 5'b00010), "mid_door4");
    applyStimulus(mk(5'b00000, 3, 4, 0, 1, 0, 5'b00010), "mid_reverse");
    applyStimulus(mk(5'b00000, 12, 1, 0, 0, 1, 5'b00000), "mid_door1");
    applyStimulus(mk(5'b00010, 1, 1, 0, 0, 1, 5'b00000), "door_recall");
    applyStimulus(mk(5'b00000, 2, 1, 0, 0, 1, 5'b00000), "door_extended");
    applyStimulus(mk(5'b00000, 1, 1, 0, 0, 0, 5'b00000), "door_closed");

    // Tick held low for ten clocks mid-travel; a call during the freeze still latches.
    applyStimulus(mk(5'b00100, 1, 1, 0, 0, 0, 5'b00100), "frz_call");
    applyStimulus(mk(5'b00000, 1, 1, 1, 1, 0, 5'b00100), "frz_depart");
    applyStimulus(mk(5'b00000, 1, 1, 1, 1, 0, 5'b00100), "frz_tick1");
    bus.tick = 1'b0;
    applyStimulus(mk(5'b00000, 3, 1, 1, 1, 0, 5'b00100), "frz_hold_a");
    applyStimulus(mk(5'b10000, 1, 1, 1, 1, 0, 5'b10100), "frz_accum");
    applyStimulus(mk(5'b00000, 6, 1, 1, 1, 0, 5'b10100), "frz_hold_b");
    bus.tick = 1'b1;
    applyStimulus(mk(5'b00000, 2, 1, 1, 1, 0, 5'b10100), "frz_resume");
    applyStimulus(mk(5'b00000, 1, 2, 1, 0, 1, 5'b10000), "frz_arrive");
    applyStimulus(mk(5'b00000, 3, 2, 1, 1, 0, 5'b10000), "frz_onward");
    applyStimulus(mk(5'b00000, 2, 2, 1, 1, 0, 5'b10000), "frz_midmove");

    // Asynchronous reset taken between clock edges.
    #2;
    rst = 1'b1;
    #2;
    expQ.push_back(mk(5'b00000, 0, 0, 1, 0, 0, 5'b00000));
    checkOutput("async_reset");
    stepClk(1);
    rst = 1'b0;

`ifdef DOOR_HOLD_EN
    applyStimulus(mk(5'b00001, 1, 0, 1, 0, 0, 5'b00001), "hold_call");
    applyStimulus(mk(5'b00000, 1, 0, 1, 0, 1, 5'b00000), "hold_open");
    bus.door_hold = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(mk(5'b00000, 1, 0, 1, 0, 1, 5'b00000), $sformatf("hold_%0d", i));
    bus.door_hold = 1'b0;
    applyStimulus(mk(5'b00000, 2, 0, 1, 0, 1, 5'b00000), "hold_release");
    applyStimulus(mk(5'b00000, 1, 0, 1, 0, 0, 5'b00000), "hold_closed");
`endif

    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
